// File: rtl/dm_responder_pkg.sv
// ---------------------------------------------------------------------------
// dm_responder_pkg
//   Shared definitions for the data-memory responder:
//     - dm_op_e     : load access codes (LW/LH/LHU/LB/LBU)
//     - DM_SW/SH/SB : store access codes (same op field, qualified by we)
//     - dm_state_e  : responder FSM states
//     - dm_size_e   : decoded access width, SZ_BAD for undefined ops
//     - accessSize(): op/we -> access width decode
// ---------------------------------------------------------------------------
package dm_responder_pkg;

    typedef enum logic [2:0] {
        DM_LW  = 3'd0,
        DM_LH  = 3'd1,
        DM_LHU = 3'd2,
        DM_LB  = 3'd3,
        DM_LBU = 3'd4
    } dm_op_e;

    localparam logic [2:0] DM_SW = 3'd0;
    localparam logic [2:0] DM_SH = 3'd1;
    localparam logic [2:0] DM_SB = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } dm_size_e;

    // Store codes 2 and 4 have no meaning even though LHU/LBU use them on
    // the load side, so the decode depends on the direction.
    function automatic dm_size_e accessSize(input logic we, input logic [2:0] op);
        dm_size_e sz;
        sz = SZ_BAD;
        if (we) begin
            case (op)
                DM_SW:   sz = SZ_WORD;
                DM_SH:   sz = SZ_HALF;
                DM_SB:   sz = SZ_BYTE;
                default: sz = SZ_BAD;
            endcase
        end else begin
            case (op)
                3'd0:       sz = SZ_WORD;
                3'd1, 3'd2: sz = SZ_HALF;
                3'd3, 3'd4: sz = SZ_BYTE;
                default:    sz = SZ_BAD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/dm_responder_lane_ext.sv
// ---------------------------------------------------------------------------
// dm_lane_ext (combinational)
//   Byte-lane handling for the data-memory responder.
//   Ports:
//     we_i        1  : 1 = store, 0 = load
//     op_i        3  : access code (dm_op_e / DM_SW/SH/SB)
//     off_i       2  : byte offset within the word (addr[1:0])
//     wdata_i    32  : right-aligned store data
//     memWord_i  32  : current array word
//     rdata_o    32  : extended load data (0 for stores)
//     merged_o   32  : word after byte-enable merge of the store data
//     fmtErr_o    1  : undefined op or misaligned access
// ---------------------------------------------------------------------------
module dm_lane_ext
    import dm_responder_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] memWord_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o,
    output logic        fmtErr_o
);

    dm_size_e    size;
    logic [15:0] halfSel;
    logic [7:0]  byteSel;

    // Decode the access width, pick the addressed lane, then either extend
    // it for a load or splice the store data into the current word.
    always_comb begin
        size    = accessSize(we_i, op_i);
        halfSel = off_i[1] ? memWord_i[31:16] : memWord_i[15:0];
        byteSel = memWord_i[{off_i, 3'b000} +: 8];

        case (size)
            SZ_WORD: fmtErr_o = |off_i;
            SZ_HALF: fmtErr_o = off_i[0];
            SZ_BYTE: fmtErr_o = 1'b0;
            default: fmtErr_o = 1'b1;
        endcase

        rdata_o = '0;
        if (!we_i) begin
            case (op_i)
                DM_LW:   rdata_o = memWord_i;
                DM_LH:   rdata_o = {{16{halfSel[15]}}, halfSel};
                DM_LHU:  rdata_o = {16'h0000, halfSel};
                DM_LB:   rdata_o = {{24{byteSel[7]}}, byteSel};
                DM_LBU:  rdata_o = {24'h000000, byteSel};
                default: rdata_o = '0;
            endcase
        end

        merged_o = memWord_i;
        if (we_i) begin
            case (op_i)
                DM_SW: merged_o = wdata_i;
                DM_SH: merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                DM_SB: merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
                default: merged_o = memWord_i;
            endcase
        end
    end

endmodule

// File: rtl/dm_responder.sv
// ---------------------------------------------------------------------------
// dm_responder
//   Memory-side end of the M-stage load/store interface. Accepts one request
//   at a time, answers after LATENCY cycles with a one-cycle rsp_valid pulse.
//   Parameters: DEPTH_WORDS (32-bit words), LATENCY (1..15).
//   Ports:
//     clk, reset (synchronous, active-high)
//     req_valid/req_ready, req_we, req_op, req_addr, req_wdata, req_pc
//     rsp_valid, rsp_rdata, rsp_err
//   Optional: define DM_WRITE_LOG_EN to print every committed store.
// ---------------------------------------------------------------------------
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072,
    parameter int LATENCY     = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

    dm_state_e   state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        we_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] mem_q [0:DEPTH_WORDS-1];

    logic        accept;
    logic [AW-1:0] wordIdx;
    logic        rangeErr;
    logic        fmtErr;
    logic        accessErr;
    logic [31:0] memWord;
    logic [31:0] loadData;
    logic [31:0] mergedWord;
    logic        storeCommit;

    assign wordIdx   = addr_q[AW+1:2];
    assign rangeErr  = addr_q >= BYTE_LIMIT;
    assign memWord   = rangeErr ? 32'h0 : mem_q[wordIdx];
    assign accessErr = rangeErr | fmtErr;

    dm_lane_ext u_lane (
        .we_i      (we_q),
        .op_i      (op_q),
        .off_i     (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .memWord_i (memWord),
        .rdata_o   (loadData),
        .merged_o  (mergedWord),
        .fmtErr_o  (fmtErr)
    );

    // Next-state logic. Acceptance overrides the RESP->IDLE default so a
    // request arriving in the response cycle starts immediately.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        req_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
        accept    = req_valid && req_ready;

        case (state_q)
            ST_WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = state_q;
        endcase

        if (accept) begin
            count_d = CNT_LOAD;
            state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
    end

    // Response outputs are pure decodes of the RESP state, so they read the
    // array as it stands before this cycle's store commit.
    always_comb begin
        rsp_valid   = (state_q == ST_RESP);
        rsp_err     = rsp_valid && accessErr;
        rsp_rdata   = (rsp_valid && !accessErr && !we_q) ? loadData : 32'h0;
        storeCommit = rsp_valid && we_q && !accessErr;
    end

    // State register and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Request capture happens only on acceptance; input changes at any
    // other time are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            pc_q    <= req_pc;
        end
    end

    // Storage array: cleared by reset, written at the end of a store's
    // RESP cycle when the access is legal.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (storeCommit) begin
            mem_q[wordIdx] <= mergedWord;
        end
    end

`ifdef DM_WRITE_LOG_EN
    // Store trace: one line per committed store.
    always_ff @(posedge clk) begin
        if (!reset && storeCommit) begin
            $display("%d@%h: *%h <= %h", $time, pc_q, {addr_q[31:2], 2'b00}, mergedWord);
        end
    end
`else
    logic unusedPc;
    assign unusedPc = ^pc_q;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// ---------------------------------------------------------------------------
// tb_dm_responder
//   Three responders (LATENCY 1, 2, 3) driven by directed and randomized
//   transactions; expected data comes from a byte-level memory model.
// ---------------------------------------------------------------------------
module tb_dm_responder;

    localparam int DEPTH = 3072;

    logic        clk;
    logic        rst       [3];
    logic        reqValid  [3];
    logic        reqReady  [3];
    logic        reqWe     [3];
    logic [2:0]  reqOp     [3];
    logic [31:0] reqAddr   [3];
    logic [31:0] reqWdata  [3];
    logic [31:0] reqPc     [3];
    logic        rspValid  [3];
    logic [31:0] rspRdata  [3];
    logic        rspErr    [3];

    logic [31:0] mdl [3][0:DEPTH-1];

    int compCnt = 0;
    int failCnt = 0;
    int cycleCnt = 0;
    int lastAccept = 0;
    int acceptLog [4];

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .req_we(reqWe[0]), .req_op(reqOp[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .req_pc(reqPc[0]), .rsp_valid(rspValid[0]), .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0]));

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut1 (
        .clk(clk), .reset(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .req_we(reqWe[1]), .req_op(reqOp[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .req_pc(reqPc[1]), .rsp_valid(rspValid[1]), .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1]));

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut2 (
        .clk(clk), .reset(rst[2]), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
        .req_we(reqWe[2]), .req_op(reqOp[2]), .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]),
        .req_pc(reqPc[2]), .rsp_valid(rspValid[2]), .rsp_rdata(rspRdata[2]), .rsp_err(rspErr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compCnt++;
        assert (obs === expv) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clearModel(input int idx);
        for (int w = 0; w < DEPTH; w++) mdl[idx][w] = 32'h0;
    endtask

    // Reference: access width from op/we, legality from alignment and range,
    // data from plain shift/mask arithmetic on the model word.
    task automatic modelTxn(input int idx, input logic we, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        int size;
        bit sgn;
        longint unsigned word, mask, val, addrL;
        int off, w;
        size = 0;
        sgn  = 0;
        if (we) begin
            if (op == 3'd0) size = 4;
            else if (op == 3'd1) size = 2;
            else if (op == 3'd3) size = 1;
        end else begin
            case (op)
                3'd0: size = 4;
                3'd1: begin size = 2; sgn = 1; end
                3'd2: size = 2;
                3'd3: begin size = 1; sgn = 1; end
                3'd4: size = 1;
                default: size = 0;
            endcase
        end
        addrL = longint'(addr);
        if (size == 0) err = 1'b1;
        else err = ((addrL % longint'(size)) != 0) || (addrL >= longint'(DEPTH * 4));
        rdata = 32'h0;
        if (!err) begin
            w    = int'(addrL / 4);
            off  = int'(addrL % 4);
            word = longint'(mdl[idx][w]);
            mask = (64'd1 << (8 * size)) - 1;
            if (!we) begin
                val = (word >> (8 * off)) & mask;
                if (sgn && (((val >> (8 * size - 1)) & 1) == 1))
                    val = val | (64'hFFFF_FFFF & ~mask);
                rdata = val[31:0];
            end else begin
                word = (word & ~(mask << (8 * off))) | ((longint'(wdata) & mask) << (8 * off));
                mdl[idx][w] = word[31:0];
            end
        end
    endtask

    // One transaction: present, wait for acceptance, then wait for the
    // response and compare latency, error flag and data with the model.
    // inResp=1 means the caller is at the negedge of a previous RESP cycle.
    task automatic applyStimulus(input int idx, input logic we, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit inResp, input bit holdValid, input string tag);
        logic [31:0] expData;
        logic        expErr;
        int waitCnt, lat;
        if (!inResp) @(negedge clk);
        modelTxn(idx, we, op, addr, wdata, expData, expErr);
        reqValid[idx] = 1'b1;
        reqWe[idx]    = we;
        reqOp[idx]    = op;
        reqAddr[idx]  = addr;
        reqWdata[idx] = wdata;
        reqPc[idx]    = $urandom;
        waitCnt = 0;
        while (!reqReady[idx] && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 50) begin
            checkOutput({tag, " accept-timeout"}, 32'(waitCnt), 32'd0);
            reqValid[idx] = 1'b0;
            return;
        end
        if (inResp) checkOutput({tag, " accepted-in-resp"}, 32'(waitCnt), 32'd0);
        lastAccept = cycleCnt;
        @(negedge clk);
        if (!holdValid) begin
            reqValid[idx] = 1'b0;
            reqWe[idx]    = $urandom_range(0, 1);
            reqOp[idx]    = 3'($urandom_range(0, 7));
            reqAddr[idx]  = $urandom;
            reqWdata[idx] = $urandom;
        end
        lat = 1;
        while (!rspValid[idx] && lat < 40) begin
            if (lat < idx + 1) checkOutput({tag, " ready-low-wait"}, 32'(reqReady[idx]), 32'd0);
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(idx + 1));
        checkOutput({tag, " err"}, 32'(rspErr[idx]), 32'(expErr));
        checkOutput({tag, " rdata"}, rspRdata[idx], expData);
    endtask

    initial begin
        int idx;
        logic [31:0] a, d;
        logic [2:0]  op;
        logic        we;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; reqValid[i] = 1'b0; reqWe[i] = 1'b0; reqOp[i] = '0;
            reqAddr[i] = '0; reqWdata[i] = '0; reqPc[i] = '0;
            clearModel(i);
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset ready%0d", i), 32'(reqReady[i]), 32'd1);
            checkOutput($sformatf("reset rspValid%0d", i), 32'(rspValid[i]), 32'd0);
            checkOutput($sformatf("reset rdata%0d", i), rspRdata[i], 32'h0);
            checkOutput($sformatf("reset err%0d", i), 32'(rspErr[i]), 32'd0);
            rst[i] = 1'b0;
        end

        // LATENCY=1: store, then load accepted in the store's RESP cycle
        applyStimulus(0, 1'b1, 3'd0, 32'h10, 32'h12345678, 0, 0, "sw10");
        applyStimulus(0, 1'b0, 3'd0, 32'h10, 32'h0, 1, 0, "lw10-fwd");
        applyStimulus(0, 1'b1, 3'd3, 32'h11, 32'h000000AB, 0, 0, "sb11");
        applyStimulus(0, 1'b0, 3'd3, 32'h11, 32'h0, 0, 0, "lb11");
        applyStimulus(0, 1'b0, 3'd4, 32'h11, 32'h0, 0, 0, "lbu11");
        applyStimulus(0, 1'b0, 3'd0, 32'h10, 32'h0, 0, 0, "lw10-merged");
        checkOutput("model lw10", mdl[0][4], 32'h1234AB78);

        // Error cases leave the array untouched
        applyStimulus(0, 1'b0, 3'd0, 32'h13, 32'h0, 0, 0, "lw13-misaligned");
        applyStimulus(0, 1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, 0, 0, "sh11-misaligned");
        applyStimulus(0, 1'b0, 3'd0, 32'h10, 32'h0, 0, 0, "lw10-after-sh");
        applyStimulus(0, 1'b1, 3'd0, 32'h3000, 32'hCAFEF00D, 0, 0, "sw3000-range");
        applyStimulus(0, 1'b0, 3'd0, 32'h2FFC, 32'h0, 0, 0, "lw2ffc-last");
        applyStimulus(0, 1'b1, 3'd2, 32'h10, 32'hFFFFFFFF, 0, 0, "store-op2-undef");
        applyStimulus(0, 1'b0, 3'd6, 32'h10, 32'h0, 0, 0, "load-op6-undef");
        applyStimulus(0, 1'b0, 3'd0, 32'h10, 32'h0, 0, 0, "lw10-final");

        // LATENCY=3: half-word sign/zero extension and ready-low window
        applyStimulus(2, 1'b1, 3'd0, 32'h10, 32'h80010002, 0, 0, "l3-sw10");
        applyStimulus(2, 1'b0, 3'd1, 32'h12, 32'h0, 0, 0, "l3-lh12");
        applyStimulus(2, 1'b0, 3'd2, 32'h12, 32'h0, 0, 0, "l3-lhu12");
        applyStimulus(2, 1'b0, 3'd1, 32'h10, 32'h0, 1, 0, "l3-lh10-b2b");

        // Reset while a store is waiting: it must vanish
        @(negedge clk);
        reqValid[2] = 1'b1; reqWe[2] = 1'b1; reqOp[2] = 3'd0;
        reqAddr[2] = 32'h20; reqWdata[2] = 32'hDEADBEEF;
        checkOutput("rst-mid ready-before", 32'(reqReady[2]), 32'd1);
        @(negedge clk);
        reqValid[2] = 1'b0;
        checkOutput("rst-mid in-wait", 32'(reqReady[2]), 32'd0);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        clearModel(2);
        checkOutput("rst-mid ready-after", 32'(reqReady[2]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("rst-mid no-rsp%0d", k), 32'(rspValid[2]), 32'd0);
            @(negedge clk);
        end
        applyStimulus(2, 1'b0, 3'd0, 32'h20, 32'h0, 1, 0, "rst-mid lw20");
        applyStimulus(2, 1'b0, 3'd1, 32'h12, 32'h0, 0, 0, "rst-mid lh12");

        // LATENCY=2 back-to-back loads with req_valid held high
        for (int k = 0; k < 4; k++)
            applyStimulus(1, 1'b1, 3'd0, 32'(4 * k), $urandom, 0, 0, $sformatf("b2b-sw%0d", k));
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1'b0, 3'd0, 32'(4 * k), 32'h0, k != 0, 1, $sformatf("b2b-lw%0d", k));
            acceptLog[k] = lastAccept;
        end
        reqValid[1] = 1'b0;
        for (int k = 1; k < 4; k++)
            checkOutput($sformatf("b2b spacing%0d", k), 32'(acceptLog[k] - acceptLog[k - 1]), 32'd2);
        @(negedge clk);
        checkOutput("b2b rsp-pulse-end", 32'(rspValid[1]), 32'd0);

        // Randomized traffic on all three responders
        for (int n = 0; n < 240; n++) begin
            idx = n % 3;
            we  = 1'($urandom_range(0, 1));
            op  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            case ($urandom_range(0, 11))
                0:       a = 32'(DEPTH * 4) + $urandom_range(0, 7);
                1:       a = $urandom;
                default: a = $urandom_range(0, 63);
            endcase
            d = $urandom;
            applyStimulus(idx, we, op, a, d, 0, 0, $sformatf("rnd%0d", n));
        end

        // Read back every touched word to confirm stores merged correctly
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 16; w++)
                applyStimulus(i, 1'b0, 3'd0, 32'(4 * w), 32'h0, 0, 0, $sformatf("final%0d_%0d", i, w));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
        $finish;
    end

endmodule
